ym_phase_seq: RTL and testbench

- Master phase and slot sequencer for the YM-style shift-register datapath.
- Divides MCLK into the non-overlapping c1/c2 enable pulses consumed by every sr/latch/counter cell.
- Tracks the current time slot within the sample frame and flags slot 0 (sync).
- Supports freeze (en) and a deferred slot-counter clear aligned to c2.

---
 rtl/ym_seq_pkg.sv | 15 +
 rtl/ym_phase_div.sv | 47 ++++
 rtl/ym_phase_seq.sv | 78 +++++++
 tb/tb_ym_phase_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ym_seq_pkg.sv
// Shared constants and helpers for the YM phase/slot sequencer.
// The OPN-family frame has 24 slots, held in a 5-bit counter.
package ym_seq_pkg;

    localparam int YM_SLOTS_OPN = 24;
    localparam int YM_SLOT_W    = 5;

    // Width of a prescaler that counts 0..2*div-1; never narrower than one bit.
    function automatic int ym_pre_width(input int div);
        int w;
        w = $clog2(2 * div);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ym_phase_div.sv
// MCLK prescaler producing the non-overlapping c1/c2 one-cycle enable pulses.
// c2 fires DIV cycles after c1, and the whole pattern repeats every 2*DIV cycles.
module ym_phase_div
    import ym_seq_pkg::*;
#(
    parameter int DIV = 3
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_en,
    output logic o_c1,
    output logic o_c2
);

    localparam int PW = ym_pre_width(DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(2 * DIV - 1);
    localparam logic [PW-1:0] PRE_MID  = PW'(DIV - 1);

    logic [PW-1:0] r_pre;
    logic          r_c1;
    logic          r_c2;
    logic          w_pre_last;
    logic          w_pre_mid;

    assign w_pre_last = (r_pre == PRE_LAST);
    assign w_pre_mid  = (r_pre == PRE_MID);

    // When frozen the prescaler holds, so resuming neither loses nor repeats a pulse.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pre <= '0;
            r_c1  <= 1'b0;
            r_c2  <= 1'b0;
        end else if (i_en) begin
            r_pre <= w_pre_last ? '0 : r_pre + PW'(1);
            r_c1  <= w_pre_last;
            r_c2  <= w_pre_mid;
        end else begin
            r_c1  <= 1'b0;
            r_c2  <= 1'b0;
        end
    end

    assign o_c1 = r_c1;
    assign o_c2 = r_c2;

endmodule

// File: rtl/ym_phase_seq.sv
// Master phase and slot sequencer: c1/c2 phase enables, slot index within the
// sample frame, slot-0 sync flag and a slot clear that is deferred to the next c2.
module ym_phase_seq
    import ym_seq_pkg::*;
#(
    parameter int DIV    = 3,
    parameter int SLOTS  = YM_SLOTS_OPN,
    parameter int SLOT_W = YM_SLOT_W
) (
    input  logic              MCLK,
    input  logic              reset,
    input  logic              en,
    input  logic              slot_clr,
    output logic              c1,
    output logic              c2,
    output logic [SLOT_W-1:0] slot,
    output logic              sync,
    output logic              clr_pend
);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);

    logic              w_c1;
    logic              w_c2;
    logic [SLOT_W-1:0] r_slot;
    logic              r_clr_pend;
    logic [SLOT_W-1:0] w_slot_nxt;
    logic              w_pend_nxt;

    ym_phase_div #(
        .DIV (DIV)
    ) u_div (
        .i_clk   (MCLK),
        .i_reset (reset),
        .i_en    (en),
        .o_c1    (w_c1),
        .o_c2    (w_c2)
    );

    // Slot advances on the edge after a c2 cycle; that edge also consumes any
    // clear request, whether pending or arriving right then.
    always_comb begin
        w_slot_nxt = r_slot;
        w_pend_nxt = r_clr_pend;
        if (w_c2) begin
            w_pend_nxt = 1'b0;
            if (r_clr_pend || slot_clr) begin
                w_slot_nxt = '0;
            end else if (r_slot == SLOT_LAST) begin
                w_slot_nxt = '0;
            end else begin
                w_slot_nxt = r_slot + SLOT_W'(1);
            end
        end else if (slot_clr) begin
            w_pend_nxt = 1'b1;
        end
    end

    always_ff @(posedge MCLK) begin
        if (reset) begin
            r_slot     <= '0;
            r_clr_pend <= 1'b0;
        end else begin
            r_slot     <= w_slot_nxt;
            r_clr_pend <= w_pend_nxt;
        end
    end

    assign c1       = w_c1;
    assign c2       = w_c2;
    assign slot     = r_slot;
    assign sync     = (r_slot == '0);
    assign clr_pend = r_clr_pend;

    a_phase_excl: assert property (@(posedge MCLK) disable iff (reset) !(w_c1 && w_c2));
    a_slot_range: assert property (@(posedge MCLK) disable iff (reset) int'(r_slot) < SLOTS);

endmodule

// File: tb/tb_ym_phase_seq.sv
// Directed bench for ym_phase_seq: DIV=3 and DIV=1 instances on one MCLK,
// driven from tables of {inputs, expected outputs} plus hand-built sequences.
module tb_ym_phase_seq;

    logic       MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    logic       rst3, en3, clr3, c1_3, c2_3, sync_3, pend_3;
    logic [4:0] slot_3;
    logic       rst1, en1, clr1, c1_1, c2_1, sync_1, pend_1;
    logic [4:0] slot_1;

    ym_phase_seq #(.DIV(3), .SLOTS(24), .SLOT_W(5)) u_dut3 (
        .MCLK     (MCLK),
        .reset    (rst3),
        .en       (en3),
        .slot_clr (clr3),
        .c1       (c1_3),
        .c2       (c2_3),
        .slot     (slot_3),
        .sync     (sync_3),
        .clr_pend (pend_3)
    );

    ym_phase_seq #(.DIV(1), .SLOTS(24), .SLOT_W(5)) u_dut1 (
        .MCLK     (MCLK),
        .reset    (rst1),
        .en       (en1),
        .slot_clr (clr1),
        .c1       (c1_1),
        .c2       (c2_1),
        .slot     (slot_1),
        .sync     (sync_1),
        .clr_pend (pend_1)
    );

    typedef struct packed {
        logic       rst;
        logic       en;
        logic       clr;
        logic       c1;
        logic       c2;
        logic       pend;
        logic [4:0] slot;
    } vec_t;

    vec_t tab3[20];
    vec_t tab1[21];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic rst, input logic en, input logic clr,
                                input logic c1, input logic c2, input logic pend,
                                input int slot);
        vec_t r;
        r.rst  = rst;
        r.en   = en;
        r.clr  = clr;
        r.c1   = c1;
        r.c2   = c2;
        r.pend = pend;
        r.slot = slot[4:0];
        return r;
    endfunction

    // Free-running DIV=3, SLOTS=24 expectation after edge s counted from reset release.
    function automatic vec_t run3(input int s);
        int sl;
        sl = (s < 3) ? 0 : (((s - 3) / 6) + 1) % 24;
        return mk(1'b0, 1'b1, 1'b0, (s % 6) == 5, (s % 6) == 2, 1'b0, sl);
    endfunction

    task automatic apply(input vec_t v, input bit d1, input string tag);
        logic [9:0] got;
        logic [9:0] exp;
        if (d1) begin
            rst1 = v.rst; en1 = v.en; clr1 = v.clr;
        end else begin
            rst3 = v.rst; en3 = v.en; clr3 = v.clr;
        end
        @(posedge MCLK);
        #1;
        exp = {v.c1, v.c2, (v.slot == 5'd0), v.pend, v.slot};
        got = d1 ? {c1_1, c2_1, sync_1, pend_1, slot_1}
                 : {c1_3, c2_3, sync_3, pend_3, slot_3};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: {c1,c2,sync,pend,slot} got %b expected %b", tag, got, exp);
        end
    endtask

    initial begin
        vec_t v;
        int   sl;

        rst3 = 1'b1; en3 = 1'b1; clr3 = 1'b0;
        rst1 = 1'b1; en1 = 1'b1; clr1 = 1'b0;

        // DIV=3: four reset edges, then E0..E15 (rst, en, clr, c1, c2, pend, slot)
        tab3[0]  = mk(1, 1, 0, 0, 0, 0, 0);
        tab3[1]  = mk(1, 1, 0, 0, 0, 0, 0);
        tab3[2]  = mk(1, 1, 0, 0, 0, 0, 0);
        tab3[3]  = mk(1, 1, 0, 0, 0, 0, 0);
        tab3[4]  = mk(0, 1, 0, 0, 0, 0, 0);   // E0
        tab3[5]  = mk(0, 1, 0, 0, 0, 0, 0);   // E1
        tab3[6]  = mk(0, 1, 0, 0, 1, 0, 0);   // E2  first c2
        tab3[7]  = mk(0, 1, 0, 0, 0, 0, 1);   // E3  slot 1
        tab3[8]  = mk(0, 1, 0, 0, 0, 0, 1);
        tab3[9]  = mk(0, 1, 0, 1, 0, 0, 1);   // E5  first c1
        tab3[10] = mk(0, 1, 0, 0, 0, 0, 1);
        tab3[11] = mk(0, 1, 0, 0, 0, 0, 1);
        tab3[12] = mk(0, 1, 0, 0, 1, 0, 1);   // E8
        tab3[13] = mk(0, 1, 0, 0, 0, 0, 2);   // E9  slot 2
        tab3[14] = mk(0, 1, 0, 0, 0, 0, 2);
        tab3[15] = mk(0, 1, 0, 1, 0, 0, 2);   // E11
        tab3[16] = mk(0, 1, 0, 0, 0, 0, 2);
        tab3[17] = mk(0, 1, 0, 0, 0, 0, 2);
        tab3[18] = mk(0, 1, 0, 0, 1, 0, 2);   // E14
        tab3[19] = mk(0, 1, 0, 0, 0, 0, 3);   // E15

        // DIV=1: two reset edges, run, clear requested while frozen, resume
        tab1[0]  = mk(1, 1, 0, 0, 0, 0, 0);
        tab1[1]  = mk(1, 1, 0, 0, 0, 0, 0);
        tab1[2]  = mk(0, 1, 0, 0, 1, 0, 0);   // E0
        tab1[3]  = mk(0, 1, 0, 1, 0, 0, 1);   // E1
        tab1[4]  = mk(0, 1, 0, 0, 1, 0, 1);
        tab1[5]  = mk(0, 1, 0, 1, 0, 0, 2);
        tab1[6]  = mk(0, 1, 0, 0, 1, 0, 2);
        tab1[7]  = mk(0, 1, 0, 1, 0, 0, 3);
        tab1[8]  = mk(0, 1, 0, 0, 1, 0, 3);
        tab1[9]  = mk(0, 1, 0, 1, 0, 0, 4);
        tab1[10] = mk(0, 1, 0, 0, 1, 0, 4);
        tab1[11] = mk(0, 1, 0, 1, 0, 0, 5);   // E9
        tab1[12] = mk(0, 0, 1, 0, 0, 1, 5);   // E10 frozen, clear requested
        tab1[13] = mk(0, 0, 0, 0, 0, 1, 5);
        tab1[14] = mk(0, 0, 0, 0, 0, 1, 5);
        tab1[15] = mk(0, 1, 0, 0, 1, 1, 5);   // E13 resume, c2
        tab1[16] = mk(0, 1, 0, 1, 0, 0, 0);   // E14 clear applied
        tab1[17] = mk(0, 1, 0, 0, 1, 0, 0);
        tab1[18] = mk(0, 1, 0, 1, 0, 0, 1);
        tab1[19] = mk(0, 1, 0, 0, 1, 0, 1);
        tab1[20] = mk(0, 1, 0, 1, 0, 0, 2);

        for (int i = 0; i < 20; i++) apply(tab3[i], 1'b0, $sformatf("phase[%0d]", i));

        for (int s = 16; s <= 221; s++) apply(run3(s), 1'b0, $sformatf("wrap E%0d", s));

        // E221 left slot 13 with c1 high; reset now must drop everything
        apply(mk(1, 1, 0, 0, 0, 0, 0), 1'b0, "midreset");
        for (int i = 4; i < 20; i++) apply(tab3[i], 1'b0, $sformatf("restart[%0d]", i));

        // Freeze for E9..E18, straight after the c2 cycle that follows E8
        for (int i = 0; i < 13; i++) apply(tab3[i], 1'b0, $sformatf("prefreeze[%0d]", i));
        for (int s = 9; s <= 18; s++) apply(mk(0, 0, 0, 0, 0, 0, 2), 1'b0, $sformatf("freeze E%0d", s));
        for (int s = 19; s <= 49; s++) apply(run3(s - 10), 1'b0, $sformatf("resume E%0d", s));

        // Deferred clear at slot 7, then a clear coincident with c2 (t is shifted time)
        for (int t = 40; t <= 58; t++) begin
            v = run3(t);
            v.clr = (t == 40) || (t == 57);
            if (t <= 44)      sl = 7;
            else if (t <= 50) sl = 0;
            else if (t <= 56) sl = 1;
            else              sl = 0;
            v.slot = sl[4:0];
            v.pend = (t <= 44);
            apply(v, 1'b0, $sformatf("clear t%0d", t));
        end
        clr3 = 1'b0;
        rst3 = 1'b1;

        for (int i = 0; i < 21; i++) apply(tab1[i], 1'b1, $sformatf("div1[%0d]", i));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
